// File: rtl/seq_det_pkg.sv
// Shared types and default sizing for the serial pattern detector.
package seq_det_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      REPORT = 2'd2
   } state_t;

   localparam int DEF_WORD_W = 8;
   localparam int DEF_PAT_W  = 3;
   localparam int DEF_CNT_W  = 4;

   // Smallest hit-count width that can hold WORD_W hits for the default word size.
   localparam int MIN_CNT_W  = $clog2(DEF_WORD_W + 1);

   function automatic int min_cnt_w(input int word_w);
      return $clog2(word_w + 1);
   endfunction

endpackage

// File: rtl/seq_match_core.sv
// Bit-serial pattern matcher: prior-bit history plus fill counter, compared
// together with the incoming bit, with optional history clear on a hit.
module seq_match_core
   import seq_det_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             data_bit,
   input  logic             push,
   input  logic             clear,
   input  logic [PAT_W-1:0] pattern,
   input  logic             overlap,
   output logic             hit
);

   localparam int FILL_W = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

   logic [PAT_W-1:0]  window;
   logic [FILL_W-1:0] fill_reg, fill_next;
   logic              full;
   logic              drop_history;

   // Only the PAT_W-1 previous bits are stored; the incoming bit completes the window.
   assign full         = (fill_reg >= FILL_MAX);
   assign hit          = push && full && (window == pattern);
   assign drop_history = clear || (hit && !overlap);

   generate
      if (PAT_W > 1) begin : g_hist
         logic [PAT_W-2:0] hist_reg;

         assign window = {hist_reg, data_bit};

         always_ff @(posedge clk) begin
            if (!rst_n || drop_history) begin
               hist_reg <= '0;
            end else if (push) begin
               hist_reg <= window[PAT_W-2:0];
            end
         end
      end else begin : g_no_hist
         assign window = data_bit;
      end
   endgenerate

   always_comb begin
      fill_next = fill_reg;
      if (drop_history) begin
         fill_next = '0;
      end else if (push && !full) begin
         fill_next = fill_reg + FILL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fill_reg <= '0;
      end else begin
         fill_reg <= fill_next;
      end
   end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Word-level pattern-hit counter: accepts a word, shifts it MSB-first through
// seq_match_core and reports the hit count. SEQ_CTRL_HIT_MASK_EN adds m_hit_mask.
module seq_detect_ctrl
   import seq_det_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int PAT_W  = DEF_PAT_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [WORD_W-1:0] s_data,
   input  logic [PAT_W-1:0]  cfg_pattern,
   input  logic              cfg_overlap,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [CNT_W-1:0]  m_count,
   output logic              busy
`ifdef SEQ_CTRL_HIT_MASK_EN
   ,
   output logic [WORD_W-1:0] m_hit_mask
`endif
);

   localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   generate
      if (PAT_W < 1 || WORD_W < PAT_W || CNT_W < min_cnt_w(WORD_W)) begin : g_bad_params
         $error("seq_detect_ctrl: illegal WORD_W/PAT_W/CNT_W combination");
      end
   endgenerate

   state_t            state_reg, state_next;
   logic [WORD_W-1:0] data_reg;
   logic [PAT_W-1:0]  pat_reg;
   logic              ovl_reg;
   logic [IDX_W-1:0]  idx_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              accept;
   logic              push;
   logic              hit;

   assign accept = (state_reg == IDLE) && s_valid;
   assign push   = (state_reg == SHIFT);

   always_comb begin
      state_next = state_reg;
      s_ready    = 1'b0;
      m_valid    = 1'b0;
      busy       = 1'b0;
      case (state_reg)
         IDLE: begin
            s_ready = 1'b1;
            if (s_valid) state_next = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (idx_reg == '0) state_next = REPORT;
         end
         REPORT: begin
            busy    = 1'b1;
            m_valid = 1'b1;
            if (m_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         data_reg  <= '0;
         pat_reg   <= '0;
         ovl_reg   <= 1'b0;
         idx_reg   <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            data_reg <= s_data;
            pat_reg  <= cfg_pattern;
            ovl_reg  <= cfg_overlap;
            idx_reg  <= IDX_W'(WORD_W - 1);
            cnt_reg  <= '0;
         end else if (push) begin
            idx_reg <= idx_reg - IDX_W'(1);
            if (hit && cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   end

   assign m_count = cnt_reg;

   seq_match_core #(
      .PAT_W (PAT_W)
   ) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_bit (data_reg[idx_reg]),
      .push     (push),
      .clear    (accept),
      .pattern  (pat_reg),
      .overlap  (ovl_reg),
      .hit      (hit)
   );

`ifdef SEQ_CTRL_HIT_MASK_EN
   logic [WORD_W-1:0] mask_reg;

   always_ff @(posedge clk) begin
      if (!rst_n || accept) begin
         mask_reg <= '0;
      end else if (push && hit) begin
         mask_reg[idx_reg] <= 1'b1;
      end
   end

   assign m_hit_mask = mask_reg;
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl (WORD_W=8, PAT_W=3, CNT_W=4);
// also checks m_hit_mask when SEQ_CTRL_HIT_MASK_EN is defined.
module tb_seq_detect_ctrl;

   localparam int WORD_W = 8;
   localparam int PAT_W  = 3;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              s_valid;
   logic              s_ready;
   logic [WORD_W-1:0] s_data;
   logic [PAT_W-1:0]  cfg_pattern;
   logic              cfg_overlap;
   logic              m_valid;
   logic              m_ready;
   logic [CNT_W-1:0]  m_count;
   logic              busy;
`ifdef SEQ_CTRL_HIT_MASK_EN
   logic [WORD_W-1:0] m_hit_mask;
`endif

   int n_cmp = 0;
   int n_err = 0;

   seq_detect_ctrl #(
      .WORD_W (WORD_W),
      .PAT_W  (PAT_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .cfg_pattern (cfg_pattern),
      .cfg_overlap (cfg_overlap),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_count     (m_count),
      .busy        (busy)
`ifdef SEQ_CTRL_HIT_MASK_EN
      ,
      .m_hit_mask  (m_hit_mask)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Window-based reference: every PAT_W-wide slice ending at bit j is a candidate;
   // without overlap a candidate may not reuse any bit of the previous counted hit.
   function automatic void ref_model(input logic [WORD_W-1:0] d, input logic [PAT_W-1:0] p,
                                     input logic o, output int cnt, output logic [WORD_W-1:0] mask);
      int last_end;
      logic [WORD_W-1:0] w;
      cnt      = 0;
      mask     = '0;
      last_end = WORD_W;
      for (int j = WORD_W - PAT_W; j >= 0; j--) begin
         w = d >> j;
         if (w[PAT_W-1:0] == p && (o || (j + PAT_W - 1) < last_end)) begin
            cnt++;
            mask[j]  = 1'b1;
            last_end = j;
         end
      end
      if (cnt > (1 << CNT_W) - 1) cnt = (1 << CNT_W) - 1;
   endfunction

   // Called #1 after an edge with the DUT idle; returns #1 after the handshake edge.
   task automatic run_word(input logic [WORD_W-1:0] d, input logic [PAT_W-1:0] p,
                           input logic o, input int stall);
      int exp_cnt;
      logic [WORD_W-1:0] exp_mask;
      ref_model(d, p, o, exp_cnt, exp_mask);
      s_valid = 1'b1; s_data = d; cfg_pattern = p; cfg_overlap = o; m_ready = 1'b0;
      @(posedge clk); #1;
      for (int k = 1; k <= WORD_W; k++) begin
         s_valid = 1'($urandom); s_data = WORD_W'($urandom);
         cfg_pattern = PAT_W'($urandom); cfg_overlap = 1'($urandom);
         m_ready = (k < WORD_W) ? 1'($urandom) : 1'b0;
         @(posedge clk); #1;
         if (k == WORD_W - 1) chk("m_valid_early", m_valid, 0);
      end
      $display("word d=%02h p=%0b ovl=%0d stall=%0d -> count=%0d exp=%0d", d, p, o, stall, m_count, exp_cnt);
      chk("m_valid", m_valid, 1);
      chk("busy_report", busy, 1);
      chk("s_ready_report", s_ready, 0);
      chk("m_count", m_count, exp_cnt);
`ifdef SEQ_CTRL_HIT_MASK_EN
      chk("m_hit_mask", m_hit_mask, exp_mask);
`endif
      for (int s = 0; s < stall; s++) begin
         m_ready = 1'b0; s_valid = 1'($urandom); s_data = WORD_W'($urandom);
         @(posedge clk); #1;
         chk("held_m_valid", m_valid, 1);
         chk("held_m_count", m_count, exp_cnt);
         chk("held_busy", busy, 1);
         chk("held_s_ready", s_ready, 0);
`ifdef SEQ_CTRL_HIT_MASK_EN
         chk("held_mask", m_hit_mask, exp_mask);
`endif
      end
      m_ready = 1'b1; s_valid = 1'($urandom);
      @(posedge clk); #1;
      m_ready = 1'b0; s_valid = 1'b0;
      chk("s_ready_after_hs", s_ready, 1);
      chk("m_valid_after_hs", m_valid, 0);
      chk("busy_after_hs", busy, 0);
   endtask

   initial begin
      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; cfg_pattern = '0; cfg_overlap = 1'b0; m_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_m_count", m_count, 0);
`ifdef SEQ_CTRL_HIT_MASK_EN
      chk("rst_mask", m_hit_mask, 0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases.
      run_word(8'hFF, 3'b111, 1'b1, 0);
      run_word(8'hFF, 3'b111, 1'b0, 0);
      run_word(8'hAA, 3'b101, 1'b1, 0);
      run_word(8'hAA, 3'b101, 1'b0, 1);
      run_word(8'h03, 3'b111, 1'b1, 0);
      run_word(8'h80, 3'b111, 1'b1, 0);
      run_word(8'hE7, 3'b111, 1'b0, 5);

      // Reset in the middle of SHIFT.
      s_valid = 1'b1; s_data = 8'hFF; cfg_pattern = 3'b111; cfg_overlap = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("midrst_s_ready", s_ready, 1);
      chk("midrst_m_valid", m_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_m_count", m_count, 0);
      $display("mid-word reset applied");
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         chk("no_report_after_rst", m_valid, 0);
      end
      run_word(8'h5A, 3'b010, 1'b1, 2);

      // Randomized words.
      for (int n = 0; n < 40; n++) begin
         run_word(WORD_W'($urandom), PAT_W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
